// File: rtl/gate_equiv_sweeper.sv
// gate_equiv_sweeper: sweeps every minterm into two implementations of one function,
// captures both truth tables and reports the mismatch count and the lowest mismatching minterm.
module gate_equiv_sweeper #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               s_a,
  input  logic               s_b,
  output logic [N_IN-1:0]    x_out,
  output logic               busy,
  output logic               done,
  output logic               equal,
  output logic [N_IN:0]      mismatch_cnt,
  output logic [N_IN-1:0]    first_bad,
  output logic               first_bad_valid,
  output logic [2**N_IN-1:0] tt_a,
  output logic [2**N_IN-1:0] tt_b
);
  localparam int M = 2**N_IN;
  localparam logic [N_IN-1:0] M_LAST = N_IN'(M - 1);
  localparam logic [3:0] SET = 4'(SETTLE);
  typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;
  state_t state_q, state_d;
  logic [N_IN-1:0] m_q, m_d, fb_q, fb_d;
  logic [3:0] cnt_q, cnt_d;
  logic [M-1:0] tt_a_q, tt_a_d, tt_b_q, tt_b_d;
  logic [N_IN:0] mm_q, mm_d;
  logic fbv_q, fbv_d, eq_q, eq_d;
  logic last;
  assign last = m_q == M_LAST;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      m_q     <= '0;
      cnt_q   <= '0;
      tt_a_q  <= '0;
      tt_b_q  <= '0;
      mm_q    <= '0;
      fb_q    <= '0;
      fbv_q   <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      tt_a_q  <= tt_a_d;
      tt_b_q  <= tt_b_d;
      mm_q    <= mm_d;
      fb_q    <= fb_d;
      fbv_q   <= fbv_d;
      eq_q    <= eq_d;
    end
  end
  always_comb begin
    state_d = state_q == IDLE   ? (start ? APPLY : IDLE) :
              state_q == APPLY  ? (cnt_q == 4'd1 ? SAMPLE : APPLY) :
              state_q == SAMPLE ? (last ? DONE : APPLY) : IDLE;
  end
  always_comb begin
    m_d    = m_q;
    cnt_d  = cnt_q;
    tt_a_d = tt_a_q;
    tt_b_d = tt_b_q;
    mm_d   = mm_q;
    fb_d   = fb_q;
    fbv_d  = fbv_q;
    eq_d   = eq_q;
    if (state_q == IDLE && start) begin
      m_d    = '0;
      cnt_d  = SET;
      tt_a_d = '0;
      tt_b_d = '0;
      mm_d   = '0;
      fb_d   = '0;
      fbv_d  = 1'b0;
      eq_d   = 1'b0;
    end else if (state_q == APPLY) begin
      cnt_d = cnt_q - 4'd1;
    end else if (state_q == SAMPLE) begin
      tt_a_d[m_q] = s_a;
      tt_b_d[m_q] = s_b;
      if (s_a != s_b) begin
        mm_d = mm_q + 1'b1;
        if (!fbv_q) begin
          fb_d  = m_q;
          fbv_d = 1'b1;
        end
      end
      // equal is settled on the edge into DONE so it is valid alongside the pulse
      if (last) eq_d = mm_d == '0;
      else begin
        m_d   = m_q + 1'b1;
        cnt_d = SET;
      end
    end
  end
  always_comb begin
    busy = state_q != IDLE;
    done = state_q == DONE;
  end
  assign x_out           = m_q;
  assign equal           = eq_q;
  assign mismatch_cnt    = mm_q;
  assign first_bad       = fb_q;
  assign first_bad_valid = fbv_q;
  assign tt_a            = tt_a_q;
  assign tt_b            = tt_b_q;
endmodule

// File: tb/tb_gate_equiv_sweeper.sv
// tb_gate_equiv_sweeper: directed checks of the sweeper with SETTLE=1 and SETTLE=3 instances
// driving a'.b against ~a|~b (or against itself).
module tb_gate_equiv_sweeper;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, start2 = 1'b0, tie = 1'b0;
  logic [1:0] x1, fb1, x2, fb2;
  logic [2:0] mm1, mm2;
  logic [3:0] ta1, tb1, ta2, tb2;
  logic busy1, done1, eq1, fbv1, sa1, sb1;
  logic busy2, done2, eq2, fbv2, sa2, sb2;
  int passed = 0, total = 0, fails = 0, dones;
  always #5 clk = ~clk;
  assign sa1 = ~x1[1] & x1[0];
  assign sb1 = tie ? sa1 : (~x1[1] | ~x1[0]);
  assign sa2 = ~x2[1] & x2[0];
  assign sb2 = ~x2[1] | ~x2[0];
  gate_equiv_sweeper #(.N_IN(2), .SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .s_a(sa1), .s_b(sb1), .x_out(x1),
    .busy(busy1), .done(done1), .equal(eq1), .mismatch_cnt(mm1), .first_bad(fb1),
    .first_bad_valid(fbv1), .tt_a(ta1), .tt_b(tb1));
  gate_equiv_sweeper #(.N_IN(2), .SETTLE(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .s_a(sa2), .s_b(sb2), .x_out(x2),
    .busy(busy2), .done(done2), .equal(eq2), .mismatch_cnt(mm2), .first_bad(fb2),
    .first_bad_valid(fbv2), .tt_a(ta2), .tt_b(tb2));
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic res1(input string tag);
    chk({tag, "_tta"}, 32'(ta1), 32'h2);
    chk({tag, "_ttb"}, 32'(tb1), 32'h7);
    chk({tag, "_mm"}, 32'(mm1), 32'd2);
    chk({tag, "_fb"}, 32'(fb1), 32'd0);
    chk({tag, "_fbv"}, 32'(fbv1), 32'd1);
    chk({tag, "_eq"}, 32'(eq1), 32'd0);
  endtask
  initial begin
    tick(2);
    chk("rst_x", 32'(x1), 0);
    chk("rst_busy", 32'(busy1), 0);
    chk("rst_done", 32'(done1), 0);
    chk("rst_mm", 32'(mm1), 0);
    chk("rst_tt", 32'({ta1, tb1}), 0);
    chk("rst_fbv_eq", 32'({fbv1, eq1}), 0);
    rst_n = 1'b1;
    tick(1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("s1_busy", 32'(busy1), 1);
    chk("s1_x0", 32'(x1), 0);
    tick(7);
    chk("s1_early", 32'(done1), 0);
    tick(1);
    chk("s1_done", 32'(done1), 1);
    chk("s1_busyd", 32'(busy1), 1);
    res1("s1");
    tick(1);
    chk("s1_pulse", 32'(done1), 0);
    chk("s1_idle", 32'(busy1), 0);
    chk("s1_hold", 32'(mm1), 2);
    tie = 1'b1;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("s2_clr_mm", 32'(mm1), 0);
    chk("s2_clr_tt", 32'(ta1), 0);
    tick(8);
    chk("s2_done", 32'(done1), 1);
    chk("s2_tta", 32'(ta1), 2);
    chk("s2_ttb", 32'(tb1), 2);
    chk("s2_mm", 32'(mm1), 0);
    chk("s2_fbv", 32'(fbv1), 0);
    chk("s2_eq", 32'(eq1), 1);
    tick(1);
    chk("s2_pulse", 32'(done1), 0);
    tie = 1'b0;
    start = 1'b1;
    dones = 0;
    for (int j = 1; j <= 12; j++) begin
      tick(1);
      start = (j == 3);
      if (j <= 8) chk($sformatf("s3_x%0d", j), 32'(x1), 32'((j - 1) / 2));
      dones += int'(done1);
    end
    chk("s3_dones", 32'(dones), 1);
    chk("s3_mm", 32'(mm1), 2);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(4);
    chk("s4_x2", 32'(x1), 2);
    chk("s4_mm_pre", 32'(mm1), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("s4_x", 32'(x1), 0);
    chk("s4_busy", 32'(busy1), 0);
    chk("s4_mm", 32'(mm1), 0);
    chk("s4_tt", 32'({ta1, tb1}), 0);
    chk("s4_fbv", 32'(fbv1), 0);
    dones = 0;
    repeat (10) begin
      tick(1);
      dones += int'(done1);
    end
    chk("s4_nodone", 32'(dones), 0);
    rst_n = 1'b1;
    tick(1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(8);
    chk("s4_done", 32'(done1), 1);
    res1("s4");
    tick(1);
    start2 = 1'b1;
    for (int j = 1; j <= 17; j++) begin
      tick(1);
      start2 = 1'b0;
      if (j <= 16) chk($sformatf("s5_x%0d", j), 32'(x2), 32'((j - 1) / 4));
      if (j == 16) chk("s5_early", 32'(done2), 0);
    end
    chk("s5_done", 32'(done2), 1);
    chk("s5_tt", 32'({ta2, tb2}), 32'h27);
    chk("s5_mm", 32'(mm2), 2);
    chk("s5_fb", 32'({fbv2, fb2}), 32'h4);
    chk("s5_eq", 32'(eq2), 0);
    start = 1'b1;
    tick(9);
    chk("s6_done1", 32'(done1), 1);
    res1("s6a");
    tick(1);
    chk("s6_gap_done", 32'(done1), 0);
    chk("s6_gap_busy", 32'(busy1), 0);
    tick(1);
    chk("s6_rearm", 32'(busy1), 1);
    chk("s6_clr_mm", 32'(mm1), 0);
    chk("s6_clr_tt", 32'({ta1, tb1}), 0);
    chk("s6_clr_fbv", 32'(fbv1), 0);
    tick(7);
    chk("s6_early", 32'(done1), 0);
    tick(1);
    chk("s6_done2", 32'(done1), 1);
    res1("s6b");
    start = 1'b0;
    tick(2);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/gate_equiv_sweeper.md
Name: gate_equiv_sweeper

Overview:
- Sequencer for the two-input gate exercises: drives a shared input vector into two implementations of the same Boolean function, e.g. gate-level vs expression form.
- Steps the vector through every minterm and lets outputs settle before sampling.
- Captures both truth tables, counts mismatching minterms and reports the first mismatch.
- Replaces hand-written per-minterm stimulus with one start/done controller instantiated beside the two implementations.

Parameters:
- N_IN, 2, number of function inputs; minterm count M = 2**N_IN; legal range 1..4.
- SETTLE, 1, cycles x_out is held before sampling; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  level, sampled only in IDLE; begins a sweep.
- s_a  input  1  output of implementation A.
- s_b  input  1  output of implementation B.
- x_out  output  N_IN  minterm index driven to both implementations; x_out[N_IN-1] is the leftmost variable (a), x_out[0] the rightmost (b).
- busy  output  1  high from APPLY through DONE inclusive.
- done  output  1  one-cycle pulse, sweep complete.
- equal  output  1  valid when done; 1 if mismatch_cnt==0.
- mismatch_cnt  output  N_IN+1  number of minterms where s_a != s_b.
- first_bad  output  N_IN  lowest minterm with a mismatch.
- first_bad_valid  output  1  first_bad holds a real minterm.
- tt_a  output  M  captured truth table of A; bit m = s_a at minterm m.
- tt_b  output  M  captured truth table of B.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; x_out=0; busy=0; done=0; equal=0; mismatch_cnt=0; first_bad=0; first_bad_valid=0; tt_a=0; tt_b=0.
  - Internal minterm counter and settle counter are cleared.
  - Reset mid-sweep aborts immediately. No done pulse. The sweep resumes only on a new start after rst_n deasserts.
- FSM states: IDLE, APPLY, SAMPLE, DONE.
- IDLE:
  - Results hold their last values.
  - On an edge with start=1: state->APPLY; m=0; x_out=0; settle counter=SETTLE.
  - On that same edge, tt_a, tt_b, mismatch_cnt, first_bad, first_bad_valid and equal are cleared.
- APPLY:
  - x_out=m held stable.
  - The counter decrements each edge; when it reaches 1, state->SAMPLE.
  - APPLY therefore lasts exactly SETTLE cycles.
- SAMPLE (one cycle, capture on its closing edge):
  - tt_a[m]<=s_a; tt_b[m]<=s_b.
  - If s_a!=s_b: mismatch_cnt++. If first_bad_valid==0, also set first_bad<=m and first_bad_valid<=1.
  - If m==M-1: state->DONE. Otherwise m++, x_out<=m+1, counter reloaded to SETTLE, state->APPLY.
- DONE (one cycle):
  - done=1; equal=(mismatch_cnt==0); busy=1.
  - Next edge: state->IDLE, done=0, busy=0.
  - x_out keeps M-1 until the next start.
- Latency: start sampled at edge k; done is high in the cycle following edge k+M*(SETTLE+1). For defaults this is 8 cycles.
- Handshake:
  - start is ignored in APPLY, SAMPLE and DONE; there is no queuing.
  - start held high continuously re-arms on the first IDLE edge after DONE, giving back-to-back sweeps with one IDLE cycle between them.
- Width rules:
  - mismatch_cnt is N_IN+1 bits, so M mismatches never wrap.
  - m wraps are never exercised because the terminal check precedes the increment.
- s_a and s_b are sampled only in SAMPLE; glitches during APPLY are ignored.

Test Plan:
1. Defaults; A=a'.b gate form, B=~a|~b; pulse start -> done 8 cycles later; tt_a=4'b0010, tt_b=4'b0111, mismatch_cnt=2, first_bad=2'b00, first_bad_valid=1, equal=0.
2. Defaults; s_b tied to s_a (A=a'.b) -> tt_a=tt_b=4'b0010, mismatch_cnt=0, first_bad_valid=0, equal=1, done exactly one cycle wide.
3. Pulse start again 3 cycles into a running sweep -> no restart; x_out sequence stays 0,0,1,1,2,2,3,3; exactly one done.
4. Assert rst_n=0 mid-cycle while x_out=2 -> all outputs zero asynchronously, no done; a new start gives a full clean sweep with results matching scenario 1.
5. SETTLE=3, scenario-1 functions -> each x_out value held 4 cycles; done at 16 cycles after the start edge; same results as scenario 1.
6. start held high across two sweeps -> first sweep results cleared on the second start edge; identical results both times; one IDLE cycle between the done pulses.
